nrzi_rx_unstuff: RTL and testbench
==================================

# nrzi_rx_unstuff

Receive-side NRZI decoder for the USB transceiver. It recovers data bits from the line, removes stuffed bits, detects SYNC and EOP, and assembles LSB-first words with a one-cycle valid strobe. It generalises the existing single-bit NRZI decoder with parametrised word width, stuff-run length and SYNC pattern, and adds error and framing reporting. It sits between the line sampler (clock recovery / DPLL) and the packet decoder.

## Interface
- DATA_W, 8, width of assembled word (2..16)
- STUFF_LEN, 6, number of consecutive decoded 1s after which one stuffed 0 follows
- SYNC_LEN, 8, length of the SYNC pattern in bits
- SYNC_PAT, 8'b1000_0000, decoded SYNC bits; bit 0 is received first (sequence 0,0,0,0,0,0,0,1)
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- bit_en  input  1  sample strobe: data_in/se0_in valid this cycle
- data_in  input  1  differential line state, 1=J, 0=K
- se0_in  input  1  single-ended-zero seen on line
- rx_data  output  DATA_W  last assembled word
- rx_valid  output  1  one-cycle pulse, rx_data new
- rx_active  output  1  high from SYNC detect until EOP/abort complete
- sync_det  output  1  one-cycle pulse on SYNC match
- eop  output  1  one-cycle pulse at end of packet
- stuff_err  output  1  one-cycle pulse on stuff violation

## Operation
- All state advances only on cycles with bit_en=1; other cycles hold state, and pulses deassert.
- NRZI decode: dec = (data_in == prev_line); prev_line <= data_in. prev_line resets to 1 (J) and is forced to 1 on return to IDLE.
- FSM states: IDLE, DATA, EOP, ABORT.
- IDLE: shift dec into a SYNC_LEN hunt register (new bit enters at MSB). A full match with SYNC_PAT pulses sync_det, goes to DATA, sets rx_active, clears bit_cnt, and sets ones_cnt=1 (the final SYNC 1 counts). se0_in is ignored in IDLE.
- DATA, priority order:
  - se0_in=1: go to EOP. Residual partial bits are discarded.
  - ones_cnt==STUFF_LEN: the bit is a stuff bit. dec=0 drops it and clears ones_cnt. dec=1 pulses stuff_err and goes to ABORT.
  - Otherwise shift dec into the word LSB-first. ones_cnt increments on 1 (saturating at STUFF_LEN) and clears on 0. When bit_cnt reaches DATA_W-1: load rx_data, pulse rx_valid, clear bit_cnt.
- EOP: wait for bit_en with se0_in=0, then pulse eop, clear rx_active, go to IDLE, clear the hunt register.
- ABORT: wait for se0_in=1, then go to EOP (eop still pulses). rx_active stays high until then.
- Reset, or reset mid-packet: all outputs 0, rx_data=0, state IDLE, counters and hunt register 0, prev_line=1.

## Timing
- All outputs are registered.
- sync_det, rx_valid, stuff_err and eop assert the clock edge after the bit_en cycle that sampled the triggering bit, and last exactly one clk.
- rx_data is stable from the rx_valid pulse until the next word.
- There is no back-pressure. The consumer must accept every rx_valid.
- Back-to-back bit_en (every clk) is supported at full rate.

## Structure
- Shared package usb_pkg holds:
  - the FSM state typedef (IDLE/DATA/EOP/ABORT)
  - the USB SYNC constant 8'b1000_0000
  - the default STUFF_LEN=6
- One natural sub-module, nrzi_bit_decode: holds prev_line and produces dec plus a qualified bit strobe. The FSM, unstuffer and assembler stay in the top.

## Test plan
- Idle J, then line 0,1,0,1,0,1,0,0 -> sync_det pulse after the 8th bit_en, rx_active=1.
- After SYNC, line 0,1,1,0,1,1,0,0 -> rx_data=8'hA5, single rx_valid pulse.
- After SYNC, 5 unchanged samples (0), one toggle (stuff), 3 unchanged -> rx_data=8'hFF, stuff bit dropped, no stuff_err.
- After SYNC, 6 unchanged samples -> stuff_err pulse, no rx_valid. Then SE0 then J -> eop pulse, rx_active=0.
- After SYNC + one byte + 3 bits, then 2 SE0 samples then J -> eop pulse, no extra rx_valid, back in IDLE with prev_line=1.
- rst_n low mid-byte -> all outputs 0 immediately. After release, a fresh SYNC is detected normally.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB receive-path types and constants.
package usb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      EOP,
      ABORT
   } rx_state_t;

   localparam logic [7:0] USB_SYNC      = 8'b1000_0000;
   localparam int         USB_STUFF_LEN = 6;

endpackage

// File: rtl/nrzi_bit_decode.sv
// NRZI line-to-bit decode: a bit is 1 when the line level did not change.
module nrzi_bit_decode (
   input  logic clk,
   input  logic rst_n,
   input  logic bit_en,
   input  logic data_in,
   input  logic force_j,
   output logic dec,
   output logic bit_stb
);

   logic prev_line;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_line <= 1'b1;
      end else if (bit_en) begin
         prev_line <= force_j ? 1'b1 : data_in;
      end
   end

   assign dec     = (data_in == prev_line);
   assign bit_stb = bit_en;

endmodule

// File: rtl/nrzi_rx_unstuff.sv
// USB receive NRZI decoder with SYNC hunt, bit unstuffing, EOP framing
// and LSB-first word assembly.
module nrzi_rx_unstuff
   import usb_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int STUFF_LEN = USB_STUFF_LEN,
   parameter int SYNC_LEN  = 8,
   parameter logic [SYNC_LEN-1:0] SYNC_PAT = SYNC_LEN'(USB_SYNC)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bit_en,
   input  logic              data_in,
   input  logic              se0_in,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              rx_active,
   output logic              sync_det,
   output logic              eop,
   output logic              stuff_err
);

   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int OW = $clog2(STUFF_LEN + 1);
   localparam int HW = $clog2(SYNC_LEN + 1);

   rx_state_t         state;
   logic [SYNC_LEN-1:0] hunt;
   logic [HW-1:0]     hunt_cnt;
   logic [BW-1:0]     bit_cnt;
   logic [OW-1:0]     ones_cnt;
   logic [DATA_W-1:0] shreg;

   logic dec;
   logic bit_stb;
   logic force_j;
   logic [SYNC_LEN-1:0] hunt_nxt;
   logic [DATA_W-1:0]   word_nxt;
   logic hunt_full;

   assign force_j   = (state == EOP) && !se0_in;
   assign hunt_nxt  = {dec, hunt[SYNC_LEN-1:1]};
   assign word_nxt  = {dec, shreg[DATA_W-1:1]};
   // Only a register filled since entering IDLE may match.
   assign hunt_full = (hunt_cnt >= HW'(SYNC_LEN - 1));

   nrzi_bit_decode u_dec (
      .clk     (clk),
      .rst_n   (rst_n),
      .bit_en  (bit_en),
      .data_in (data_in),
      .force_j (force_j),
      .dec     (dec),
      .bit_stb (bit_stb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         hunt      <= '0;
         hunt_cnt  <= '0;
         bit_cnt   <= '0;
         ones_cnt  <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         rx_active <= 1'b0;
         sync_det  <= 1'b0;
         eop       <= 1'b0;
         stuff_err <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         sync_det  <= 1'b0;
         eop       <= 1'b0;
         stuff_err <= 1'b0;
         if (bit_stb) begin
            unique case (state)
               IDLE: begin
                  hunt <= hunt_nxt;
                  if (hunt_cnt != HW'(SYNC_LEN))
                     hunt_cnt <= hunt_cnt + 1'b1;
                  if (hunt_full && hunt_nxt == SYNC_PAT) begin
                     sync_det  <= 1'b1;
                     rx_active <= 1'b1;
                     state     <= DATA;
                     bit_cnt   <= '0;
                     ones_cnt  <= OW'(1);
                  end
               end
               DATA: begin
                  if (se0_in) begin
                     state <= EOP;
                  end else if (ones_cnt == OW'(STUFF_LEN)) begin
                     if (dec) begin
                        stuff_err <= 1'b1;
                        state     <= ABORT;
                     end else begin
                        ones_cnt <= '0;
                     end
                  end else begin
                     shreg    <= word_nxt;
                     ones_cnt <= dec ? ones_cnt + 1'b1 : '0;
                     if (bit_cnt == BW'(DATA_W - 1)) begin
                        rx_data  <= word_nxt;
                        rx_valid <= 1'b1;
                        bit_cnt  <= '0;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
               EOP: begin
                  if (!se0_in) begin
                     eop       <= 1'b1;
                     rx_active <= 1'b0;
                     state     <= IDLE;
                     hunt      <= '0;
                     hunt_cnt  <= '0;
                  end
               end
               ABORT: begin
                  if (se0_in)
                     state <= EOP;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nrzi_rx_unstuff.sv
// Self-checking bench for nrzi_rx_unstuff using a transmit-side model.
module tb_nrzi_rx_unstuff;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          bit_en = 1'b0;
   logic          data_in = 1'b1;
   logic          se0_in = 1'b0;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_active;
   logic          sync_det;
   logic          eop;
   logic          stuff_err;

   int total = 0;
   int bad = 0;
   int n_valid = 0;
   int n_sync = 0;
   int n_eop = 0;
   int n_serr = 0;
   logic [DW-1:0] got[$];

   logic tx_line = 1'b1;
   int   tx_ones = 0;
   logic use_gaps = 1'b0;

   always #5 clk = ~clk;

   nrzi_rx_unstuff dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_en    (bit_en),
      .data_in   (data_in),
      .se0_in    (se0_in),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_active (rx_active),
      .sync_det  (sync_det),
      .eop       (eop),
      .stuff_err (stuff_err)
   );

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) begin
            got.push_back(rx_data);
            n_valid++;
         end
         n_sync += int'(sync_det);
         n_eop  += int'(eop);
         n_serr += int'(stuff_err);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic clear_mon();
      n_valid = 0;
      n_sync = 0;
      n_eop = 0;
      n_serr = 0;
      got.delete();
   endtask

   task automatic send(input logic d, input logic s);
      bit_en = 1'b1;
      data_in = d;
      se0_in = s;
      @(negedge clk);
      #1;
   endtask

   task automatic gap();
      bit_en = 1'b0;
      data_in = 1'($urandom);
      se0_in = 1'($urandom);
      @(negedge clk);
      #1;
   endtask

   task automatic idle_j(input int n);
      for (int i = 0; i < n; i++) send(1'b1, 1'b0);
      tx_line = 1'b1;
   endtask

   // Transmit model: NRZI encode plus a stuffed 0 after STUFF_LEN ones.
   task automatic tx_bit(input logic b);
      if (!b) tx_line = ~tx_line;
      send(tx_line, 1'b0);
      if (use_gaps && $urandom_range(3) == 0) gap();
      tx_ones = b ? tx_ones + 1 : 0;
      if (tx_ones == 6) begin
         tx_line = ~tx_line;
         send(tx_line, 1'b0);
         tx_ones = 0;
      end
   endtask

   task automatic tx_sync();
      tx_line = 1'b1;
      tx_ones = 0;
      for (int i = 0; i < 7; i++) tx_bit(1'b0);
      tx_bit(1'b1);
   endtask

   task automatic tx_eop();
      send(1'b0, 1'b1);
      send(1'b0, 1'b1);
      send(1'b1, 1'b0);
      tx_line = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if ({rx_data, rx_valid, rx_active, sync_det, eop, stuff_err} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got %h/%b%b%b%b%b want all 0",
                  rx_data, rx_valid, rx_active, sync_det, eop, stuff_err);
      end
      rst_n = 1'b1;
      @(negedge clk);
      #1;
   endtask

   task automatic test_sync();
      logic [7:0] seq;
      seq = 8'b0010_1010;
      idle_j(4);
      for (int i = 0; i < 8; i++) begin
         send(seq[i], 1'b0);
         if (i == 6) begin
            total++;
            if (sync_det !== 1'b0) begin
               bad++;
               $display("FAIL sync_early: got %b want 0", sync_det);
            end
         end
      end
      total++;
      if (sync_det !== 1'b1 || rx_active !== 1'b1) begin
         bad++;
         $display("FAIL sync_det: got sync=%b act=%b want 1/1", sync_det, rx_active);
      end
      gap();
      total++;
      if (sync_det !== 1'b0 || rx_active !== 1'b1) begin
         bad++;
         $display("FAIL sync_width: got sync=%b act=%b want 0/1", sync_det, rx_active);
      end
      tx_eop();
      total++;
      if (eop !== 1'b1 || rx_active !== 1'b0) begin
         bad++;
         $display("FAIL sync_eop: got eop=%b act=%b want 1/0", eop, rx_active);
      end
   endtask

   task automatic test_byte_a5();
      logic [7:0] seq;
      seq = 8'b0011_0110;
      idle_j(3);
      tx_sync();
      for (int i = 0; i < 8; i++) begin
         send(seq[i], 1'b0);
         if (i == 6) begin
            total++;
            if (rx_valid !== 1'b0) begin
               bad++;
               $display("FAIL a5_early: got valid=%b want 0", rx_valid);
            end
         end
      end
      total++;
      if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
         bad++;
         $display("FAIL a5_word: got v=%b d=%h want 1/a5", rx_valid, rx_data);
      end
      gap();
      total++;
      if (rx_valid !== 1'b0 || rx_data !== 8'hA5) begin
         bad++;
         $display("FAIL a5_hold: got v=%b d=%h want 0/a5", rx_valid, rx_data);
      end
      tx_eop();
   endtask

   task automatic test_stuff_ok();
      idle_j(3);
      tx_sync();
      clear_mon();
      for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
      send(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
      total++;
      if (n_valid != 1 || rx_data !== 8'hFF || n_serr != 0) begin
         bad++;
         $display("FAIL stuff_drop: got n=%0d d=%h err=%0d want 1/ff/0",
                  n_valid, rx_data, n_serr);
      end
      tx_eop();
   endtask

   task automatic test_stuff_err();
      idle_j(3);
      tx_sync();
      clear_mon();
      for (int i = 0; i < 6; i++) send(1'b0, 1'b0);
      total++;
      if (stuff_err !== 1'b1 || n_valid != 0) begin
         bad++;
         $display("FAIL stuff_err: got err=%b n=%0d want 1/0", stuff_err, n_valid);
      end
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      total++;
      if (stuff_err !== 1'b0 || rx_active !== 1'b1 || n_eop != 0 || n_valid != 0) begin
         bad++;
         $display("FAIL abort_hold: got err=%b act=%b eop=%0d n=%0d want 0/1/0/0",
                  stuff_err, rx_active, n_eop, n_valid);
      end
      send(1'b0, 1'b1);
      send(1'b1, 1'b0);
      total++;
      if (eop !== 1'b1 || rx_active !== 1'b0) begin
         bad++;
         $display("FAIL abort_eop: got eop=%b act=%b want 1/0", eop, rx_active);
      end
   endtask

   task automatic test_partial_eop();
      logic [7:0] b;
      logic [7:0] seq;
      seq = 8'b0010_1010;
      b = 8'($urandom);
      idle_j(3);
      tx_sync();
      clear_mon();
      for (int k = 0; k < 8; k++) tx_bit(b[k]);
      for (int k = 0; k < 3; k++) tx_bit(1'($urandom));
      send(1'b0, 1'b1);
      send(1'b0, 1'b1);
      send(1'b0, 1'b0);
      total++;
      if (eop !== 1'b1 || rx_active !== 1'b0 || n_valid != 1) begin
         bad++;
         $display("FAIL partial_eop: got eop=%b act=%b n=%0d want 1/0/1",
                  eop, rx_active, n_valid);
      end
      total++;
      if (got.size() != 1 || got[0] !== b) begin
         bad++;
         $display("FAIL partial_word: got %h want %h", rx_data, b);
      end
      for (int i = 0; i < 8; i++) send(seq[i], 1'b0);
      total++;
      if (sync_det !== 1'b1) begin
         bad++;
         $display("FAIL resync_j: got sync=%b want 1", sync_det);
      end
      tx_eop();
   endtask

   task automatic test_reset_mid();
      idle_j(3);
      tx_sync();
      for (int k = 0; k < 4; k++) tx_bit(1'($urandom));
      total++;
      if (rx_active !== 1'b1) begin
         bad++;
         $display("FAIL mid_active: got %b want 1", rx_active);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({rx_data, rx_valid, rx_active, sync_det, eop, stuff_err} !== '0) begin
         bad++;
         $display("FAIL mid_reset: got %h/%b%b%b%b%b want all 0",
                  rx_data, rx_valid, rx_active, sync_det, eop, stuff_err);
      end
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      idle_j(3);
      tx_sync();
      total++;
      if (sync_det !== 1'b1 || rx_active !== 1'b1) begin
         bad++;
         $display("FAIL mid_resync: got sync=%b act=%b want 1/1", sync_det, rx_active);
      end
      tx_eop();
   endtask

   task automatic test_random(input int npkt, input logic gaps);
      logic [7:0] exp[$];
      logic [7:0] b;
      int nb;
      int np;
      use_gaps = gaps;
      for (int p = 0; p < npkt; p++) begin
         exp.delete();
         nb = $urandom_range(4, 1);
         np = $urandom_range(DW - 1, 0);
         idle_j($urandom_range(4, 1));
         clear_mon();
         tx_sync();
         for (int j = 0; j < nb; j++) begin
            b = 8'($urandom);
            if ($urandom_range(3) == 0) b = 8'hFF;
            exp.push_back(b);
            for (int k = 0; k < 8; k++) tx_bit(b[k]);
         end
         for (int k = 0; k < np; k++) tx_bit(1'($urandom));
         tx_eop();
         total++;
         if (n_sync != 1 || n_eop != 1 || n_serr != 0 || rx_active !== 1'b0) begin
            bad++;
            $display("FAIL rand_frame p%0d: got sync=%0d eop=%0d err=%0d act=%b want 1/1/0/0",
                     p, n_sync, n_eop, n_serr, rx_active);
         end
         total++;
         if (got.size() != exp.size()) begin
            bad++;
            $display("FAIL rand_count p%0d: got %0d want %0d", p, got.size(), exp.size());
         end else begin
            for (int j = 0; j < exp.size(); j++) begin
               if (got[j] !== exp[j]) begin
                  bad++;
                  $display("FAIL rand_word p%0d.%0d: got %h want %h", p, j, got[j], exp[j]);
               end
            end
         end
      end
      use_gaps = 1'b0;
   endtask

   task automatic test_back_to_back();
      test_random(6, 1'b0);
   endtask

   initial begin
      @(negedge clk);
      #1;
      test_reset();
      test_sync();
      test_byte_a5();
      test_stuff_ok();
      test_stuff_err();
      test_partial_eop();
      test_reset_mid();
      test_random(20, 1'b1);
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
